// File: rtl/ram16k_arb_pkg.sv
// Shared definitions for the two-port RAM16K arbiter.
// Holds the FSM state encoding, default widths and port identifiers.
package ram16k_arb_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 16;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/ram16k_arbiter_rr.sv
// Combinational 2-way round-robin pick.
// On a tie the port that did not win last time is granted.
module rr_arb2
   import ram16k_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = PORT0;
      if (req0 && req1) begin
         gnt_id = ~last;
      end else if (req1) begin
         gnt_id = PORT1;
      end
   end

endmodule

// File: rtl/ram16k_arbiter.sv
// Shares one RAM16K (sync write, async read) between two req/ack requesters.
// Each transaction takes IDLE -> ACCESS -> RESP, one cycle per state.
module ram16k_arbiter
   import ram16k_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [DATA_W-1:0] ram_in,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_load,
   input  logic [DATA_W-1:0] ram_out
);

   state_t              state;
   state_t              state_nxt;
   logic                latch;
   logic                last;
   logic                gnt_valid;
   logic                gnt_id;

   logic                lat_id;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

   rr_arb2 u_rr_arb2 (
      .req0      (req0),
      .req1      (req1),
      .last      (last),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      unique case (state)
         IDLE: begin
            if (gnt_valid) begin
               latch     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode from the registered state and the latched command.
   always_comb begin
      busy     = (state == ACCESS) || (state == RESP);
      ack0     = (state == RESP) && (lat_id == PORT0);
      ack1     = (state == RESP) && (lat_id == PORT1);
      ram_load = (state == ACCESS) && lat_we && !reset;
   end

   assign ram_address = lat_addr;
   assign ram_in      = lat_wdata;

   // Command latch: the winner's inputs are frozen here, so later
   // changes on the requester side cannot disturb the access.
   always_ff @(posedge clk) begin
      if (reset) begin
         last      <= PORT1;
         lat_id    <= PORT0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (latch) begin
         last   <= gnt_id;
         lat_id <= gnt_id;
         if (gnt_id == PORT1) begin
            lat_we    <= we1;
            lat_addr  <= addr1;
            lat_wdata <= wdata1;
         end else begin
            lat_we    <= we0;
            lat_addr  <= addr0;
            lat_wdata <= wdata0;
         end
      end
   end

   // Read capture at the end of ACCESS; writes leave rdata untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if ((state == ACCESS) && !lat_we) begin
         if (lat_id == PORT1) begin
            rdata1 <= ram_out;
         end else begin
            rdata0 <= ram_out;
         end
      end
   end

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Directed bench for ram16k_arbiter with a behavioural RAM16K model
// and an ack-driven scoreboard.
module tb_ram16k_arbiter;

   localparam int AW = 14;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          ack0, ack1, busy, ram_load;
   logic [DW-1:0] rdata0, rdata1, ram_in, ram_out;
   logic [AW-1:0] ram_address;

   always #5 clk = ~clk;

   ram16k_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .busy(busy), .ram_in(ram_in), .ram_address(ram_address),
      .ram_load(ram_load), .ram_out(ram_out)
   );

   // RAM16K model: synchronous write, asynchronous read, plus a preload path.
   logic [DW-1:0] mem [0:16383];
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_a = '0;
   logic [DW-1:0] pre_d = '0;

   always @(posedge clk) begin
      if (pre_en) mem[pre_a] <= pre_d;
      else if (ram_load) mem[ram_address] <= ram_in;
   end
   assign ram_out = mem[ram_address];

   int cyc = 0;
   int loads = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (ram_load) loads <= loads + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic          p;
      logic [DW-1:0] d;
      int            c;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every ack pops one expectation and checks port, data and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (ack0 || ack1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack got ack0=%0d ack1=%0d want none (cycle %0d)",
                     ack0, ack1, cyc);
         end else begin
            e = q.pop_front();
            chk("dual_ack", {31'b0, ack0 & ack1}, 32'd0);
            chk("ack_port", {31'b0, ack1}, {31'b0, e.p});
            chk("ack_rdata", {16'b0, (ack1 ? rdata1 : rdata0)}, {16'b0, e.d});
            chk("ack_cycle", cyc, e.c);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      if (p) begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end
   endtask

   task automatic clr_req(input logic p);
      if (p) req1 = 1'b0;
      else   req0 = 1'b0;
   endtask

   task automatic wait_ack(input logic p);
      int n = 0;
      while (!(p ? ack1 : ack0) && n < 12) begin
         tick();
         n++;
      end
      if (n >= 12) begin
         total++;
         bad++;
         $display("FAIL ack_timeout port=%0d got no ack want ack within 12 cycles", p);
      end
   endtask

   task automatic xact(input logic p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
      set_req(p, we, a, d);
      q.push_back('{p: p, d: exp_rd, c: cyc + 2});
      wait_ack(p);
      clr_req(p);
      tick();
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pre_a = a; pre_d = d; pre_en = 1'b1;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_ack0", {31'b0, ack0}, 32'd0);
      chk("rst_ack1", {31'b0, ack1}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_load", {31'b0, ram_load}, 32'd0);
      chk("rst_addr", {18'b0, ram_address}, 32'd0);
      chk("rst_in", {16'b0, ram_in}, 32'd0);
      chk("rst_rdata0", {16'b0, rdata0}, 32'd0);
      chk("rst_rdata1", {16'b0, rdata1}, 32'd0);
   endtask

   initial begin
      int n;
      int loads0;

      // Reset and preload a few words.
      tick();
      preload(14'h0020, 16'h7777);
      preload(14'h0030, 16'h0000);
      preload(14'h0100, 16'h5555);
      tick();
      chk_reset_vals();
      reset = 1'b0;
      tick();

      // Port 0 write then read back.
      xact(1'b0, 1'b1, 14'h0005, 16'hBEEF, 16'h0000);
      chk("mem_5", {16'b0, mem[14'h0005]}, 32'h0000BEEF);
      xact(1'b0, 1'b0, 14'h0005, 16'h0000, 16'hBEEF);

      // Fresh reset, then a tie: port 0 wins, port 1 three cycles later.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      n = cyc;
      set_req(1'b0, 1'b1, 14'h3FFF, 16'h1111);
      set_req(1'b1, 1'b0, 14'h3FFF, 16'h0000);
      q.push_back('{p: 1'b0, d: 16'h0000, c: n + 2});
      q.push_back('{p: 1'b1, d: 16'h1111, c: n + 5});
      wait_ack(1'b0);
      clr_req(1'b0);
      wait_ack(1'b1);
      clr_req(1'b1);
      tick();

      // Both ports requesting continuously: alternate 0,1,0,1,0,1.
      n = cyc;
      set_req(1'b0, 1'b0, 14'h0005, 16'h0000);
      set_req(1'b1, 1'b0, 14'h3FFF, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         q.push_back('{p: 1'b0, d: 16'hBEEF, c: n + 2 + 6 * i});
         q.push_back('{p: 1'b1, d: 16'h1111, c: n + 5 + 6 * i});
      end
      repeat (17) tick();
      clr_req(1'b0);
      clr_req(1'b1);
      tick();

      // Port 1 changes its address after latching; the latched one is used.
      set_req(1'b1, 1'b1, 14'h0010, 16'h4242);
      q.push_back('{p: 1'b1, d: 16'h1111, c: cyc + 2});
      tick();
      addr1 = 14'h0020;
      wdata1 = 16'h9999;
      #1;
      chk("acc_addr", {18'b0, ram_address}, 32'h00000010);
      chk("acc_in", {16'b0, ram_in}, 32'h00004242);
      chk("acc_load", {31'b0, ram_load}, 32'd1);
      wait_ack(1'b1);
      clr_req(1'b1);
      tick();
      chk("mem_10", {16'b0, mem[14'h0010]}, 32'h00004242);
      chk("mem_20", {16'b0, mem[14'h0020]}, 32'h00007777);

      // Reset during ACCESS of a port 0 write: nothing commits, no ack.
      set_req(1'b0, 1'b1, 14'h0100, 16'hDEAD);
      tick();
      reset = 1'b1;
      #1;
      chk("rst_acc_load", {31'b0, ram_load}, 32'd0);
      tick();
      clr_req(1'b0);
      chk_reset_vals();
      chk("mem_100", {16'b0, mem[14'h0100]}, 32'h00005555);
      reset = 1'b0;
      repeat (4) tick();

      // Port 1 write leaves rdata1 alone; the read returns the stored zero.
      loads0 = loads;
      xact(1'b1, 1'b1, 14'h0040, 16'hABCD, 16'h0000);
      chk("wr_rdata1", {16'b0, rdata1}, 32'd0);
      chk("mem_40", {16'b0, mem[14'h0040]}, 32'h0000ABCD);
      xact(1'b1, 1'b0, 14'h0030, 16'h0000, 16'h0000);
      chk("rd_rdata1", {16'b0, rdata1}, 32'd0);
      chk("load_cycles", loads - loads0, 32'd1);

      repeat (3) tick();
      chk("queue_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram16k_arbiter.md
# ram16k_arbiter

Two-port round-robin arbiter that shares a single RAM16K data memory (16-bit words, 14-bit address, synchronous write, asynchronous read) between two requesters, e.g. the CPU data port (port 0) and a DMA/screen-refresh engine (port 1). It accepts one single-word read or write per transaction over a req/ack handshake. It latches the winning command, drives the RAM's `in`/`address`/`load` for exactly one cycle, captures the read word, and returns it with a one-cycle acknowledge. It sits between the requesters and the RAM16K instance; the RAM itself stays outside this block.

## Interface
Parameters:
- `ADDR_W`, 14: RAM address width.
- `DATA_W`, 16: RAM word width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  request from port 0 / port 1 (level).
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  word address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  registered read data; valid when the matching ack is high, held until that port's next read.
- `busy`  out  1  high in ACCESS and RESP.
- `ram_in`  out  DATA_W  to RAM16K `in`.
- `ram_address`  out  ADDR_W  to RAM16K `address`.
- `ram_load`  out  1  to RAM16K `load`.
- `ram_out`  in  DATA_W  from RAM16K `out` (async read).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any `reqN` high: pick a winner and latch its `we`, `addr` and `wdata` plus the winner id. Go to ACCESS.
- **ACCESS**
  - `ram_address` = latched addr.
  - `ram_in` = latched wdata.
  - `ram_load` = latched we.
  - At the cycle end, the RAM commits the write, or the arbiter captures `ram_out` into the winner's `rdata`. Go to RESP.
- **RESP**
  - Winner's `ackN` = 1. Go to IDLE.
  - Requests are ignored in RESP.
- **Arbitration**
  - Round-robin using a `last` pointer, updated on each latch.
  - One requester: it wins.
  - Both requesting: the port ≠ `last` wins.
  - Reset value of `last` is 1, so port 0 wins the first tie.
- **Requester rule**
  - Hold `req`, `we`, `addr` and `wdata` stable until sampled in IDLE. Changes after latching are ignored.
  - Deassert `req` on the edge where `ack` is seen.
  - If `req` is still high in the following IDLE cycle, it is a new transaction.
- Write transactions leave `rdata` unchanged.
- `ram_address` and `ram_in` hold their last driven values outside ACCESS.
- `ram_load` is 0 outside ACCESS.
- **Reset**
  - Reset values: state IDLE, `last` = 1, `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `busy` = 0, `ram_address` = 0, `ram_in` = 0, `ram_load` = 0.
  - `ram_load` is gated by `!reset`: a write in ACCESS during a reset cycle must not commit.
  - Reset mid-transaction drops it: no ack, and the pending request must be re-issued.

## Timing
- Request seen high at edge E (state IDLE) → ACCESS in cycle E+1 → `ack` high in cycle E+2.
- Fixed 3-cycle latency, uncontended.
- Peak throughput: one transaction per 3 cycles.
- Two continuously requesting ports alternate: 0, 1, 0, 1 …
- Worst-case wait for a requesting port: one foreign transaction, i.e. grant within 3 cycles.
- `rdata` updates on the same edge that raises `ack`.

## Structure
- Shared package `ram16k_arb_pkg`:
  - state enum (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2)
  - `ADDR_W` / `DATA_W` default constants
  - port-id constants PORT0 = 1'b0, PORT1 = 1'b1
- Sub-module `rr_arb2`: combinational 2-way round-robin pick (inputs: `req0`, `req1`, `last`; outputs: `gnt_valid`, `gnt_id`). The top owns the `last` register and the FSM.

## Test plan
- Reset, then port 0 writes 0xBEEF @ 0x0005, then reads @ 0x0005 → `ack0` at E+2 each; read returns `rdata0` = 0xBEEF; `ack1` never high.
- Simultaneous requests after reset (port 0 write 0x1111 @ 0x3FFF, port 1 read @ 0x3FFF) → port 0 served first; `ack1` 3 cycles after `ack0` with `rdata1` = 0x1111.
- Both ports requesting continuously for 6 transactions → grants alternate 0, 1, 0, 1, 0, 1; no ack gap longer than 3 cycles.
- Port 1 changes `addr1` from 0x0010 to 0x0020 in the cycle after latching → access uses 0x0010; the RAM word at 0x0020 is unchanged.
- Assert reset during ACCESS of a port 0 write of 0xDEAD @ 0x0100 → `ram_load` stays 0; word @ 0x0100 keeps its old value; no `ack0`; all outputs at reset values next cycle.
- Port 1 write 0xABCD followed by a port 1 read of another address holding 0x0000 → `rdata1` unchanged (0) after the write; 0x0000 after the read; `ram_load` high for exactly one cycle total.
